// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM state
// type and small decode helpers used by the top and the alignment datapath.
package load_store_unit_pkg;

  // RV32I load/store funct3 width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_DONE
  } state_e;

  // Stores only know B/H/W; loads additionally have the unsigned B/H forms.
  function automatic logic f3_valid(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Natural alignment of the access width against the low address bits.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-request and data-memory signals of the load/store unit bundled into one
// interface. Signal names carry the direction as seen from the LSU.
// modport master: the LSU itself (initiator of memory cycles).
// modport slave : the surroundings (execute stage + data memory).
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  // core request side
  logic              i_req;
  logic              i_we;
  logic [2:0]        i_funct3;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_wdata;
  logic              o_busy;
  logic              o_done;
  logic              o_fault;
  logic [31:0]       o_rdata;
  // data memory side
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wd;
  logic              o_mem_wen;
  logic              o_mem_ren;
  logic [31:0]       i_mem_rd;

  modport master (
    input  i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rd,
    output o_busy, o_done, o_fault, o_rdata,
    output o_mem_addr, o_mem_wd, o_mem_wen, o_mem_ren
  );

  modport slave (
    output i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rd,
    input  o_busy, o_done, o_fault, o_rdata,
    input  o_mem_addr, o_mem_wd, o_mem_wen, o_mem_ren
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane handling for the load/store unit: sign/zero extension of
// loaded data and the byte/halfword merge used by the SB/SH read-modify-write.
// Target data always sits in lane 0 because memory is addressed per byte.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [31:0] mem_rd,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  // Extend the lane-0 field of the read word according to the load width.
  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    load_data = mem_rd;
    case (f3)
      F3_B:    load_data = {{24{mem_rd[7]}}, mem_rd[7:0]};
      F3_H:    load_data = {{16{mem_rd[15]}}, mem_rd[15:0]};
      F3_BU:   load_data = {24'h0, mem_rd[7:0]};
      F3_HU:   load_data = {16'h0, mem_rd[15:0]};
      default: load_data = mem_rd;
    endcase
  end

  // Overlay the store bytes onto the word just read; upper bytes are preserved.
  always_comb begin
    merge_data = wdata;
    case (f3)
      F3_B:    merge_data = {mem_rd[31:8], wdata[7:0]};
      F3_H:    merge_data = {mem_rd[31:16], wdata[15:0]};
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory interface. Converts RV32I
// load/store requests into word-wide memory read/write cycles; SB/SH are done
// as read-modify-write, loads are extended from lane 0.
// Optional build macro: MISALIGN_TRAP_EN -- misaligned H/W accesses take the
// fault path instead of being issued to the byte-granular memory.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  load_store_unit_if.master bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;

  logic              reject;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;

  load_store_unit_align u_align (
    .f3         (f3_q),
    .mem_rd     (bus.i_mem_rd),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Next-state and register updates for the access sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    reject  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_req) begin
          addr_d  = bus.i_addr;
          we_d    = bus.i_we;
          f3_d    = bus.i_funct3;
          wdata_d = bus.i_wdata;
`ifdef MISALIGN_TRAP_EN
          reject  = !f3_valid(bus.i_we, bus.i_funct3) ||
                    f3_misaligned(bus.i_funct3, bus.i_addr[1:0]);
`else
          reject  = !f3_valid(bus.i_we, bus.i_funct3);
`endif
          fault_d = reject;
          if (reject) begin
            state_d = ST_DONE;
          end else if (bus.i_we && (bus.i_funct3 == F3_W)) begin
            // full-word store needs no read: write data is final right away
            wd_d    = bus.i_wdata;
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // read data is valid now, one cycle after the read enable
        if (we_q) begin
          wd_d    = merge_data;
          state_d = ST_WR;
        end else begin
          rdata_d = load_data;
          state_d = ST_DONE;
        end
      end
      ST_WR: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers: synchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      wd_q    <= 32'h0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Latched request fields; only meaningful while busy.
  // NOTE: these datapath registers are deliberately not reset; they are always loaded before they are used.
  always_ff @(posedge i_clk) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    f3_q    <= f3_d;
    wdata_q <= wdata_d;
  end

  assign bus.o_busy     = (state_q != ST_IDLE);
  assign bus.o_done     = (state_q == ST_DONE);
  assign bus.o_fault    = (state_q == ST_DONE) && fault_q;
  assign bus.o_rdata    = rdata_q;
  assign bus.o_mem_addr = addr_q;
  assign bus.o_mem_wd   = wd_q;
  // Enables are gated by reset so an abort never completes a partial RMW write.
  assign bus.o_mem_ren  = (state_q == ST_RD) && !i_rst;
  assign bus.o_mem_wen  = (state_q == ST_WR) && !i_rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array memory model, directed
// scenarios from the data sheet and a randomized sweep compared against a
// byte-level reference model. Honours MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // ---------------- memory model (environment) ----------------
  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic [31:0] mem_rd_q = 32'h0;
  logic [7:0]  mem_a;
  int          ren_cnt = 0;
  int          wen_cnt = 0;
  int          both_cnt = 0;

  assign bus.i_mem_rd = mem_rd_q;

  always @(posedge clk) begin
    mem_a = bus.o_mem_addr[7:0];
    if (bus.o_mem_ren && bus.o_mem_wen) both_cnt++;
    if (bus.o_mem_ren) begin
      mem_rd_q <= {mem[8'(mem_a + 8'd3)], mem[8'(mem_a + 8'd2)],
                   mem[8'(mem_a + 8'd1)], mem[mem_a]};
      ren_cnt++;
    end
    if (bus.o_mem_wen) begin
      mem[mem_a]                <= bus.o_mem_wd[7:0];
      mem[8'(mem_a + 8'd1)]     <= bus.o_mem_wd[15:8];
      mem[8'(mem_a + 8'd2)]     <= bus.o_mem_wd[23:16];
      mem[8'(mem_a + 8'd3)]     <= bus.o_mem_wd[31:24];
      wen_cnt++;
    end
  end

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], mem[8'(a + 8'd1)], mem[a]};
  endfunction

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    return {ref_mem[8'(a + 8'd3)], ref_mem[8'(a + 8'd2)], ref_mem[8'(a + 8'd1)], ref_mem[a]};
  endfunction

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic logic ref_reject(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic bad;
    if (we) bad = (f3 > 3'd2);
    else    bad = !((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
`ifdef MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) bad = 1'b1;
    if ((f3 == 3'd2) && (addr % 4 != 0)) bad = 1'b1;
`endif
    return bad;
  endfunction

  task automatic scramble_inputs();
    bus.i_req    = 1'($urandom);
    bus.i_we     = 1'($urandom);
    bus.i_funct3 = 3'($urandom);
    bus.i_addr   = $urandom;
    bus.i_wdata  = $urandom;
  endtask

  // Issue one access, noise the inputs while busy, check against the model.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    logic        rej;
    int          exp_lat, exp_ren, exp_wen, nbytes, cyc, r0, w0, b0;
    logic        done_seen;
    logic [31:0] w;
    logic [7:0]  a;
    a   = addr[7:0];
    rej = ref_reject(we, f3, addr);
    exp_ren = 0;
    exp_wen = 0;
    if (rej) begin
      exp_lat = 1;
    end else if (!we) begin
      exp_lat = 3;
      exp_ren = 1;
      w = ref_word(a);
      case (f3)
        3'd0:    exp_rdata = 32'($signed(w[7:0]));
        3'd1:    exp_rdata = 32'($signed(w[15:0]));
        3'd4:    exp_rdata = 32'(w[7:0]);
        3'd5:    exp_rdata = 32'(w[15:0]);
        default: exp_rdata = w;
      endcase
    end else begin
      exp_wen = 1;
      exp_ren = (f3 == 3'd2) ? 0 : 1;
      exp_lat = (f3 == 3'd2) ? 2 : 4;
      nbytes  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      for (int i = 0; i < nbytes; i++) ref_mem[8'(a + 8'(i))] = wdata[8*i +: 8];
    end

    @(negedge clk);
    bus.i_req    = 1'b1;
    bus.i_we     = we;
    bus.i_funct3 = f3;
    bus.i_addr   = addr;
    bus.i_wdata  = wdata;
    r0 = ren_cnt;
    w0 = wen_cnt;
    b0 = both_cnt;
    @(posedge clk);
    #1;
    scramble_inputs();
    cyc = 0;
    done_seen = 1'b0;
    while (cyc < 20 && !done_seen) begin
      @(negedge clk);
      cyc++;
      if (bus.o_done) done_seen = 1'b1;
      else scramble_inputs();
    end
    bus.i_req = 1'b0;
    check("done_seen", 32'(done_seen), 32'd1);
    check("latency", cyc, exp_lat);
    check("fault", 32'(bus.o_fault), 32'(rej));
    check("rdata", bus.o_rdata, exp_rdata);
    @(negedge clk);
    check("busy_after", 32'(bus.o_busy), 32'd0);
    check("done_pulse", 32'(bus.o_done), 32'd0);
    check("ren_count", ren_cnt - r0, exp_ren);
    check("wen_count", wen_cnt - w0, exp_wen);
    check("ren_and_wen", both_cnt - b0, 0);
    if (we && !rej) check("mem_word", mem_word(a), ref_word(a));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    int r0, w0;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end
    mem[8'h10] = 8'hBB; mem[8'h11] = 8'hAA; mem[8'h12] = 8'h99; mem[8'h13] = 8'h88;
    ref_mem[8'h10] = 8'hBB; ref_mem[8'h11] = 8'hAA; ref_mem[8'h12] = 8'h99; ref_mem[8'h13] = 8'h88;

    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_funct3 = 3'd0;
    bus.i_addr = 32'h0; bus.i_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ren", 32'(bus.o_mem_ren), 32'd0);
    check("rst_wen", 32'(bus.o_mem_wen), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    check("rst_fault", 32'(bus.o_fault), 32'd0);
    check("rst_rdata", bus.o_rdata, 32'h0);
    check("rst_wd", bus.o_mem_wd, 32'h0);

    // loads of the preset word
    run_op(1'b0, 3'd2, 32'h10, 32'h0);
    check("lw_10", bus.o_rdata, 32'h8899AABB);
    run_op(1'b0, 3'd0, 32'h10, 32'h0);
    check("lb_10", bus.o_rdata, 32'hFFFFFFBB);
    run_op(1'b0, 3'd4, 32'h10, 32'h0);
    check("lbu_10", bus.o_rdata, 32'h000000BB);
    run_op(1'b0, 3'd1, 32'h10, 32'h0);
    check("lh_10", bus.o_rdata, 32'hFFFFAABB);
    run_op(1'b0, 3'd5, 32'h10, 32'h0);
    check("lhu_10", bus.o_rdata, 32'h0000AABB);

    // read-modify-write stores
    run_op(1'b1, 3'd0, 32'h10, 32'h12345678);
    check("sb_word", mem_word(8'h10), 32'h8899AA78);
    run_op(1'b1, 3'd1, 32'h10, 32'h12345678);
    check("sh_word", mem_word(8'h10), 32'h88995678);

    // full-word store and readback
    run_op(1'b1, 3'd2, 32'h20, 32'hDEADBEEF);
    run_op(1'b0, 3'd2, 32'h20, 32'h0);
    check("lw_20", bus.o_rdata, 32'hDEADBEEF);

    // reset while the SB write cycle is pending
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_funct3 = 3'd0;
    bus.i_addr = 32'h10; bus.i_wdata = 32'hA5A5A5A5;
    r0 = ren_cnt;
    w0 = wen_cnt;
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_wr", 32'(bus.o_mem_wen), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_wen_gated", 32'(bus.o_mem_wen), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_rdata = 32'h0;
    @(negedge clk);
    check("abort_busy", 32'(bus.o_busy), 32'd0);
    check("abort_done", 32'(bus.o_done), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 32'(bus.o_done), 32'd0);
    end
    check("abort_ren", ren_cnt - r0, 1);
    check("abort_wen", wen_cnt - w0, 0);
    check("abort_word", mem_word(8'h10), 32'h88995678);
    check("abort_rdata", bus.o_rdata, 32'h0);

    // invalid width code and misaligned word load
    run_op(1'b0, 3'd3, 32'h10, 32'h0);
    run_op(1'b1, 3'd7, 32'h30, 32'h11111111);
    run_op(1'b0, 3'd2, 32'h11, 32'h0);
`ifndef MISALIGN_TRAP_EN
    check("lw_11", bus.o_rdata, {ref_mem[8'h14], 24'h889956});
`endif

    // randomized sweep
    for (int n = 0; n < 300; n++) begin
      run_op(1'($urandom), 3'($urandom), 32'($urandom_range(0, 251)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
